// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin arbiter and its requester clients.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARB,
    LOCKED
  } arb_client_state_e;

  // Bits needed to hold every value from 0 up to and including max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val <= 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/arb_sync_fifo.sv
// Synchronous FIFO with registered head data, empty and ready flags.
module arb_sync_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             ready,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
  logic             full_n;

  assign wr_ptr_n = wr_ptr + {{AW{1'b0}}, push};
  assign rd_ptr_n = rd_ptr + {{AW{1'b0}}, pop};
  assign full_n   = (wr_ptr_n[AW] != rd_ptr_n[AW]) &&
                    (wr_ptr_n[AW-1:0] == rd_ptr_n[AW-1:0]);
  assign level    = wr_ptr - rd_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      rdata  <= '0;
      empty  <= 1'b1;
      ready  <= 1'b0;
    end else begin
      if (push) mem[wr_ptr[AW-1:0]] <= wdata;
      wr_ptr <= wr_ptr_n;
      rd_ptr <= rd_ptr_n;
      // The incoming beat becomes the new head when it lands in the head slot.
      if (push && (wr_ptr[AW-1:0] == rd_ptr_n[AW-1:0]))
        rdata <= wdata;
      else
        rdata <= mem[rd_ptr_n[AW-1:0]];
      empty <= (wr_ptr_n == rd_ptr_n);
      ready <= !full_n;
    end
  end

endmodule

// File: rtl/arb_req_client.sv
// Requester-side arbiter endpoint: buffers beats, holds req/gnt, locks bursts, flags starvation.
//   state  | meaning
//   IDLE   | nothing buffered, no request
//   ARB    | head beat requested, selection not held
//   LOCKED | mid-burst, arbiter selection held on this client
module arb_req_client
  import arb_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int DEPTH         = 4,
  parameter int MAX_BURST     = 4,
  parameter int STARVE_CYCLES = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  input  logic                  in_last_i,
  output logic                  req_o,
  output logic                  lock_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  last_o,
  input  logic                  gnt_i,
  output logic                  starve_o,
  output logic                  burst_err_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int BW = cnt_width(MAX_BURST);
  localparam int WW = cnt_width(STARVE_CYCLES);

  arb_client_state_e state, state_n;
  logic [DATA_WIDTH:0] head;
  logic [AW:0]         level;
  logic [BW-1:0]       bcnt;
  logic [WW-1:0]       wcnt;
  logic                empty, push, fire, forced, has_more;

  assign push = in_valid_i & in_ready_o;
  assign fire = req_o & gnt_i;

  arb_sync_fifo #(
    .WIDTH(DATA_WIDTH + 1),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk_i),
    .rst  (rst_i),
    .push (push),
    .wdata({in_last_i, in_data_i}),
    .pop  (fire),
    .rdata(head),
    .empty(empty),
    .ready(in_ready_o),
    .level(level)
  );

  assign data_o   = head[DATA_WIDTH-1:0];
  assign forced   = (bcnt == BW'(MAX_BURST - 1));
  assign last_o   = !empty & (head[DATA_WIDTH] | forced);
  // Whether a beat is still buffered after this cycle's pop.
  assign has_more = (level > (AW+1)'(1)) | push;
  assign starve_o = (wcnt == WW'(STARVE_CYCLES));

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    req_o   = 1'b0;
    lock_o  = 1'b0;
    case (state)
      IDLE: begin
        if (push || !empty) state_n = ARB;
      end
      ARB: begin
        req_o = 1'b1;
        if (fire) begin
          if (!last_o)      state_n = LOCKED;
          else if (!has_more) state_n = IDLE;
        end
      end
      LOCKED: begin
        req_o  = !empty;
        lock_o = 1'b1;
        if (fire && last_o) state_n = has_more ? ARB : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bcnt        <= '0;
      wcnt        <= '0;
      burst_err_o <= 1'b0;
    end else begin
      if (fire && last_o)      bcnt <= '0;
      else if (fire)           bcnt <= bcnt + BW'(1);
      else if (state != LOCKED) bcnt <= '0;

      if (!req_o || fire)      wcnt <= '0;
      else if (!starve_o)      wcnt <= wcnt + WW'(1);

      burst_err_o <= fire && forced && !head[DATA_WIDTH];
    end
  end

endmodule

// File: tb/tb_arb_req_client.sv
// Directed bench for arb_req_client with hand-computed expectations per cycle.
module tb_arb_req_client;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_last;
  logic [31:0] in_data, data;
  logic        req, lock, last, gnt, starve, burst_err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  arb_req_client #(
    .DATA_WIDTH(32), .DEPTH(4), .MAX_BURST(4), .STARVE_CYCLES(16)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_data_i(in_data), .in_last_i(in_last),
    .req_o(req), .lock_o(lock), .data_o(data), .last_o(last),
    .gnt_i(gnt), .starve_o(starve), .burst_err_o(burst_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic l);
    in_valid = v;
    in_data  = d;
    in_last  = l;
  endtask

  initial begin
    rst = 1'b1;
    gnt = 1'b0;
    drive(1'b0, 32'h0, 1'b0);
    repeat (3) tick();
    check("rst_ready", in_ready, 0);
    check("rst_req", req, 0);
    check("rst_lock", lock, 0);
    check("rst_last", last, 0);
    check("rst_starve", starve, 0);
    check("rst_berr", burst_err, 0);
    check("rst_data", data, 0);
    rst = 1'b0;
    tick();
    check("post_rst_ready", in_ready, 1);

    // Single beat with grant tied high
    gnt = 1'b1;
    drive(1'b1, 32'hA1, 1'b1);
    check("single_req_c0", req, 0);
    tick();
    drive(1'b0, 32'h0, 1'b0);
    check("single_req_c1", req, 1);
    check("single_data", data, 32'hA1);
    check("single_last", last, 1);
    check("single_lock_c1", lock, 0);
    tick();
    check("single_req_c2", req, 0);
    check("single_lock_c2", lock, 0);
    gnt = 1'b0;

    // 3-beat burst, one-cycle grants two idle cycles apart
    drive(1'b1, 32'hB0, 1'b0);
    tick();
    drive(1'b1, 32'hB1, 1'b0);
    check("b3_req_c1", req, 1);
    check("b3_data_a0", data, 32'hB0);
    tick();
    drive(1'b1, 32'hB2, 1'b1);
    tick();
    drive(1'b0, 32'h0, 1'b0);
    check("b3_data_a1", data, 32'hB0);
    check("b3_lock_a", lock, 0);
    check("b3_last_a", last, 0);
    tick();
    check("b3_data_a2", data, 32'hB0);
    gnt = 1'b1;
    tick();
    gnt = 1'b0;
    check("b3_lock_b", lock, 1);
    check("b3_data_b0", data, 32'hB1);
    check("b3_last_b", last, 0);
    check("b3_req_b", req, 1);
    tick();
    check("b3_data_b1", data, 32'hB1);
    tick();
    check("b3_data_b2", data, 32'hB1);
    gnt = 1'b1;
    tick();
    gnt = 1'b0;
    check("b3_data_c0", data, 32'hB2);
    check("b3_last_c", last, 1);
    check("b3_lock_c0", lock, 1);
    tick();
    tick();
    check("b3_data_c1", data, 32'hB2);
    check("b3_lock_c1", lock, 1);
    gnt = 1'b1;
    tick();
    gnt = 1'b0;
    check("b3_lock_end", lock, 0);
    check("b3_req_end", req, 0);

    // Starvation: 20 cycles without grant
    drive(1'b1, 32'h55, 1'b1);
    tick();
    drive(1'b0, 32'h0, 1'b0);
    check("stv_req", req, 1);
    repeat (15) tick();
    check("stv_r15", starve, 0);
    tick();
    check("stv_r16", starve, 1);
    repeat (3) tick();
    check("stv_r19", starve, 1);
    check("stv_data", data, 32'h55);
    tick();
    check("stv_r20", starve, 1);
    gnt = 1'b1;
    tick();
    gnt = 1'b0;
    check("stv_clear", starve, 0);
    check("stv_req_end", req, 0);

    // Fill to full, then grant and push together
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h10 + i, 1'b1);
      tick();
    end
    drive(1'b1, 32'h99, 1'b1);
    gnt = 1'b1;
    check("full_ready", in_ready, 0);
    check("full_head", data, 32'h10);
    tick();
    drive(1'b0, 32'h0, 1'b0);
    check("full_ready_next", in_ready, 1);
    check("full_d1", data, 32'h11);
    tick();
    check("full_d2", data, 32'h12);
    tick();
    check("full_d3", data, 32'h13);
    tick();
    check("full_no_push", req, 0);
    gnt = 1'b0;

    // 6-beat burst truncated at MAX_BURST=4
    gnt = 1'b1;
    drive(1'b1, 32'h20, 1'b0);
    tick();
    drive(1'b1, 32'h21, 1'b0);
    check("mb_d1", data, 32'h20);
    check("mb_lock1", lock, 0);
    tick();
    drive(1'b1, 32'h22, 1'b0);
    check("mb_d2", data, 32'h21);
    check("mb_lock2", lock, 1);
    check("mb_last2", last, 0);
    tick();
    drive(1'b1, 32'h23, 1'b0);
    check("mb_d3", data, 32'h22);
    tick();
    drive(1'b1, 32'h24, 1'b0);
    check("mb_d4", data, 32'h23);
    check("mb_last4", last, 1);
    check("mb_lock4", lock, 1);
    check("mb_berr4", burst_err, 0);
    tick();
    drive(1'b1, 32'h25, 1'b1);
    check("mb_berr5", burst_err, 1);
    check("mb_lock5", lock, 0);
    check("mb_d5", data, 32'h24);
    check("mb_last5", last, 0);
    check("mb_req5", req, 1);
    tick();
    drive(1'b0, 32'h0, 1'b0);
    check("mb_berr6", burst_err, 0);
    check("mb_lock6", lock, 1);
    check("mb_d6", data, 32'h25);
    check("mb_last6", last, 1);
    tick();
    check("mb_lock_end", lock, 0);
    check("mb_req_end", req, 0);
    gnt = 1'b0;

    // Reset mid-burst after two fires
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h30 + i, i == 3);
      tick();
    end
    drive(1'b0, 32'h0, 1'b0);
    gnt = 1'b1;
    check("mr_lock0", lock, 0);
    tick();
    check("mr_lock1", lock, 1);
    check("mr_d1", data, 32'h31);
    tick();
    check("mr_d2", data, 32'h32);
    gnt = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mr_req", req, 0);
    check("mr_lock", lock, 0);
    check("mr_data", data, 0);
    check("mr_last", last, 0);
    check("mr_ready", in_ready, 0);
    check("mr_berr", burst_err, 0);
    check("mr_starve", starve, 0);
    tick();
    check("mr_ready_after", in_ready, 1);
    check("mr_empty", req, 0);
    drive(1'b1, 32'h40, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b0);
    check("mr_new_req", req, 1);
    check("mr_new_lock", lock, 0);
    check("mr_new_data", data, 32'h40);
    gnt = 1'b1;
    tick();
    check("mr_gap_lock", lock, 1);
    check("mr_gap_req", req, 0);
    drive(1'b1, 32'h41, 1'b1);
    tick();
    drive(1'b0, 32'h0, 1'b0);
    check("mr_tail_data", data, 32'h41);
    check("mr_tail_last", last, 1);
    check("mr_tail_req", req, 1);
    tick();
    check("mr_tail_lock", lock, 0);
    check("mr_tail_idle", req, 0);
    gnt = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
